capture_arbiter: RTL

Shares one capture register between four requesters that each present a data word. It sequences grant, capture and hold phases so that only one source is loaded at a time. The loaded data is clocked from the single system clock through a load-enable; there are no derived clocks. It sits between the OR-combined request sources and the downstream capture/compare logic. A 2-bit mode input selects disabled, round-robin or fixed-priority arbitration.

---
 rtl/capture_arbiter.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/capture_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : capture_arbiter
// Purpose  : Shares one capture register between four requesters. A
//            grant / capture / hold sequence makes sure only one source is
//            loaded at a time. The mode input selects disabled, round-robin,
//            or fixed-priority arbitration (low index highest, or high index
//            highest).
// Ports    : clk        system clock, all state changes on posedge
//            reset      asynchronous, active-high reset
//            req[3:0]   level-sensitive request, one bit per requester
//            data       four DATA_W words, slice k = data[k*DATA_W +: DATA_W]
//            mode[1:0]  00 off, 01 round-robin, 10 low-first, 11 high-first
//            gnt[3:0]   registered one-hot grant (high only during GRANT)
//            cap_valid  one-cycle pulse when cap_data is updated
//            cap_data   captured word, held between captures
//            cap_src    index of the requester that was last captured
//            busy       high whenever the arbiter is not idle
// Revision : 1.0 - initial release
// ============================================================================
module capture_arbiter #(
  parameter int DATA_W      = 8,
  parameter int HOLD_CYCLES = 2   // legal range 1..15
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [3:0]          req,
  input  logic [4*DATA_W-1:0] data,
  input  logic [1:0]          mode,
  output logic [3:0]          gnt,
  output logic                cap_valid,
  output logic [DATA_W-1:0]   cap_data,
  output logic [1:0]          cap_src,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF = 2'b00;
  localparam logic [1:0] MODE_RR  = 2'b01;
  localparam logic [1:0] MODE_LO  = 2'b10;
  localparam logic [1:0] MODE_HI  = 2'b11;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  state_t              state;
  logic [1:0]          rr_ptr;
  logic [3:0]          hold_cnt;
  logic [1:0]          win_idx;   // requester granted in the current GRANT
  logic [1:0]          sel;       // combinational winner from IDLE inputs
  logic [1:0]          rr_idx;
  logic [DATA_W-1:0]   win_data;

  // Winner selection. Each loop walks from the lowest priority candidate to
  // the highest so the last hit is the winner.
  always_comb begin
    sel    = 2'd0;
    rr_idx = 2'd0;
    case (mode)
      MODE_RR: begin
        // Offset 0 (rr_ptr itself) is the highest priority; 2-bit add wraps.
        for (int i = 3; i >= 0; i--) begin
          rr_idx = rr_ptr + 2'(i);
          if (req[rr_idx]) sel = rr_idx;
        end
      end
      MODE_LO: begin
        for (int i = 3; i >= 0; i--) begin
          if (req[i]) sel = 2'(i);
        end
      end
      MODE_HI: begin
        for (int i = 0; i < 4; i++) begin
          if (req[i]) sel = 2'(i);
        end
      end
      default: sel = 2'd0;
    endcase
  end

  assign win_data = data[int'(win_idx)*DATA_W +: DATA_W];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      gnt       <= 4'b0000;
      cap_valid <= 1'b0;
      cap_data  <= '0;
      cap_src   <= 2'd0;
      busy      <= 1'b0;
      rr_ptr    <= 2'd0;
      hold_cnt  <= 4'd0;
      win_idx   <= 2'd0;
    end else begin
      cap_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (mode != MODE_OFF && req != 4'b0000) begin
            win_idx <= sel;
            gnt     <= 4'b0001 << sel;
            busy    <= 1'b1;
            state   <= GRANT;
          end
        end
        GRANT: begin
          gnt <= 4'b0000;
          // The granted requester must still be asking on the closing edge,
          // otherwise the grant is abandoned without touching the capture.
          if (req[win_idx]) begin
            cap_data  <= win_data;
            cap_src   <= win_idx;
            cap_valid <= 1'b1;
            rr_ptr    <= win_idx + 2'd1;
            hold_cnt  <= HOLD_LOAD;
            state     <= HOLD;
          end else begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        HOLD: begin
          if (hold_cnt == 4'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            hold_cnt <= hold_cnt - 4'd1;
          end
        end
        default: begin
          gnt   <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire
